// File: rtl/pipe_perf_pkg.sv
// Shared types and sizing helpers for the pipeline performance counter block.
package pipe_perf_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } perf_state_e;

    // Read-select width: one slot for the cycle counter plus one per event channel.
    function automatic int unsigned rd_width(input int unsigned n_evt);
        return $clog2(n_evt + 1);
    endfunction

endpackage

// File: rtl/perf_ctr_cell.sv
// One wrap-or-saturate event counter with synchronous clear and an overflow pulse.
module perf_ctr_cell #(
    parameter int unsigned CNT_W = 32,
    parameter bit          SAT   = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             ovf
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic at_max;

    assign at_max = (cnt == CNT_MAX);
    // Overflow is reported on every increment attempted at all-ones, wrap or saturate.
    assign ovf    = inc & ~clr & at_max;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            if (!at_max) begin
                cnt <= cnt + CNT_W'(1);
            end else if (!SAT) begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/pipe_perf_counter.sv
// Pipeline performance counter: cycle counter plus N_EVT event counters with shadow snapshot.
// Optional sticky overflow flags and interrupt are built only when PERF_OVERFLOW_IRQ_EN is defined.
module pipe_perf_counter
    import pipe_perf_pkg::*;
#(
    parameter int unsigned        N_EVT      = 4,
    parameter int unsigned        CNT_W      = 32,
    parameter int unsigned        CYC_LIMIT  = 30,
    parameter bit                 SAT        = 1'b0,
    parameter logic [N_EVT-1:0]   DEFER_MASK = '0,
    localparam int unsigned       RD_W       = rd_width(N_EVT)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             clr_i,
    input  logic [N_EVT-1:0] evt_i,
    input  logic             snap_i,
    input  logic [RD_W-1:0]  rd_sel_i,
    output logic [CNT_W-1:0] rd_data_o,
    output logic [1:0]       state_o,
    output logic             done_o,
    output logic [N_EVT:0]   ovf_o,
    output logic             irq_o
);

    localparam int unsigned      N_CTR    = N_EVT + 1;
    localparam bit               LIMITED  = (CYC_LIMIT != 0);
    localparam logic [CNT_W-1:0] LIM_LAST = CNT_W'(CYC_LIMIT - 1);

    perf_state_e      state_q, state_d;
    logic             run_c;
    logic [N_EVT:0]   inc_c;
    logic [N_EVT:0]   ovf_pulse;
    logic [N_EVT-1:0] pend_q;
    logic [CNT_W-1:0] cnt      [N_CTR];
    logic [CNT_W-1:0] shadow_q [N_CTR];

    assign run_c = (state_q == ST_RUN);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The cycle counter reaches CYC_LIMIT on the same edge we enter DONE, so test LIMIT-1.
    always_comb begin
        state_d = state_q;
        if (clr_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (start_i) state_d = ST_RUN;
                ST_RUN: begin
                    if (LIMITED && (cnt[0] == LIM_LAST)) begin
                        state_d = ST_DONE;
                    end else if (!start_i) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_DONE: state_d = ST_DONE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign state_o = state_q;
    assign done_o  = (state_q == ST_DONE);

    // Deferred channels count from pend in any state so the last RUN-cycle event lands.
    always_comb begin
        inc_c    = '0;
        inc_c[0] = run_c;
        for (int i = 0; i < N_EVT; i++) begin
            inc_c[i+1] = DEFER_MASK[i] ? pend_q[i] : (run_c & evt_i[i]);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pend_q <= '0;
        end else if (clr_i) begin
            pend_q <= '0;
        end else begin
            pend_q <= DEFER_MASK & evt_i & {N_EVT{run_c}};
        end
    end

    for (genvar g = 0; g < N_CTR; g++) begin : g_ctr
        perf_ctr_cell #(
            .CNT_W (CNT_W),
            .SAT   (SAT)
        ) u_cell (
            .clk   (clk_i),
            .rst_n (rst_i),
            .inc   (inc_c[g]),
            .clr   (clr_i),
            .cnt   (cnt[g]),
            .ovf   (ovf_pulse[g])
        );
    end

    // Snapshot takes pre-edge live values, so it coexists with a same-edge clear.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int k = 0; k < N_CTR; k++) begin
                shadow_q[k] <= '0;
            end
        end else if (snap_i) begin
            for (int k = 0; k < N_CTR; k++) begin
                shadow_q[k] <= cnt[k];
            end
        end
    end

    always_comb begin
        rd_data_o = '0;
        for (int k = 0; k < N_CTR; k++) begin
            if (rd_sel_i == RD_W'(k)) begin
                rd_data_o = shadow_q[k];
            end
        end
    end

`ifdef PERF_OVERFLOW_IRQ_EN
    logic [N_EVT:0] ovf_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ovf_q <= '0;
        end else if (clr_i) begin
            ovf_q <= '0;
        end else begin
            ovf_q <= ovf_q | ovf_pulse;
        end
    end

    assign ovf_o = ovf_q;
    assign irq_o = |ovf_q;
`else
    logic unused_ovf;

    assign unused_ovf = ^ovf_pulse;
    assign ovf_o      = '0;
    assign irq_o      = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_perf_counter.sv
// Randomized and directed bench for pipe_perf_counter; four configurations share one stimulus stream.
module tb_pipe_perf_counter;

`ifdef PERF_OVERFLOW_IRQ_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       clr = 1'b0;
    logic       snap = 1'b0;
    logic [3:0] evt = '0;
    logic [2:0] rd_sel = '0;

    logic [1:0]  st_w   [4];
    logic        done_w [4];
    logic [4:0]  ovf_w  [4];
    logic        irq_w  [4];
    logic [31:0] rd_a;
    logic [15:0] rd_b;
    logic [7:0]  rd_c, rd_d;

    // Instance configuration as seen by the reference model.
    int unsigned lim_c [4] = '{30, 30, 0, 0};
    bit          sat_c [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    bit [3:0]    dfr_c [4] = '{4'b0000, 4'b0001, 4'b0000, 4'b0100};
    int unsigned w_c   [4] = '{32, 16, 8, 8};

    logic [1:0]  st_m   [4];
    logic [63:0] cnt_m  [4][5];
    logic [63:0] shd_m  [4][5];
    bit          pend_m [4][4];
    bit          ovf_m  [4][5];

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipe_perf_counter #(.N_EVT(4), .CNT_W(32), .CYC_LIMIT(30), .SAT(1'b0), .DEFER_MASK(4'b0000)) u_a (
        .clk_i(clk), .rst_i(rst), .start_i(start), .clr_i(clr), .evt_i(evt), .snap_i(snap),
        .rd_sel_i(rd_sel), .rd_data_o(rd_a), .state_o(st_w[0]), .done_o(done_w[0]),
        .ovf_o(ovf_w[0]), .irq_o(irq_w[0]));

    pipe_perf_counter #(.N_EVT(4), .CNT_W(16), .CYC_LIMIT(30), .SAT(1'b0), .DEFER_MASK(4'b0001)) u_b (
        .clk_i(clk), .rst_i(rst), .start_i(start), .clr_i(clr), .evt_i(evt), .snap_i(snap),
        .rd_sel_i(rd_sel), .rd_data_o(rd_b), .state_o(st_w[1]), .done_o(done_w[1]),
        .ovf_o(ovf_w[1]), .irq_o(irq_w[1]));

    pipe_perf_counter #(.N_EVT(4), .CNT_W(8), .CYC_LIMIT(0), .SAT(1'b0), .DEFER_MASK(4'b0000)) u_c (
        .clk_i(clk), .rst_i(rst), .start_i(start), .clr_i(clr), .evt_i(evt), .snap_i(snap),
        .rd_sel_i(rd_sel), .rd_data_o(rd_c), .state_o(st_w[2]), .done_o(done_w[2]),
        .ovf_o(ovf_w[2]), .irq_o(irq_w[2]));

    pipe_perf_counter #(.N_EVT(4), .CNT_W(8), .CYC_LIMIT(0), .SAT(1'b1), .DEFER_MASK(4'b0100)) u_d (
        .clk_i(clk), .rst_i(rst), .start_i(start), .clr_i(clr), .evt_i(evt), .snap_i(snap),
        .rd_sel_i(rd_sel), .rd_data_o(rd_d), .state_o(st_w[3]), .done_o(done_w[3]),
        .ovf_o(ovf_w[3]), .irq_o(irq_w[3]));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] obs_rd(input int k);
        case (k)
            0:       return 64'(rd_a);
            1:       return 64'(rd_b);
            2:       return 64'(rd_c);
            default: return 64'(rd_d);
        endcase
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            st_m[k] = 2'b00;
            for (int j = 0; j < 5; j++) begin
                cnt_m[k][j] = '0;
                shd_m[k][j] = '0;
                ovf_m[k][j] = 1'b0;
            end
            for (int i = 0; i < 4; i++) pend_m[k][i] = 1'b0;
        end
    endtask

    // Behavioural model of one clock edge, applied to every configuration.
    task automatic model_step(input bit s, input bit c, input bit [3:0] e, input bit sn);
        for (int k = 0; k < 4; k++) begin
            logic [63:0] mx;
            bit run, inc;
            mx = (w_c[k] >= 64) ? '1 : ((64'd1 << w_c[k]) - 64'd1);
            if (sn) for (int j = 0; j < 5; j++) shd_m[k][j] = cnt_m[k][j];
            if (c) begin
                st_m[k] = 2'b00;
                for (int j = 0; j < 5; j++) begin
                    cnt_m[k][j] = '0;
                    ovf_m[k][j] = 1'b0;
                end
                for (int i = 0; i < 4; i++) pend_m[k][i] = 1'b0;
            end else begin
                run = (st_m[k] == 2'b01);
                for (int j = 0; j < 5; j++) begin
                    if (j == 0) inc = run;
                    else if (dfr_c[k][j-1]) inc = pend_m[k][j-1];
                    else inc = run && e[j-1];
                    if (inc) begin
                        if (cnt_m[k][j] == mx) begin
                            ovf_m[k][j] = 1'b1;
                            if (!sat_c[k]) cnt_m[k][j] = '0;
                        end else begin
                            cnt_m[k][j] = cnt_m[k][j] + 64'd1;
                        end
                    end
                end
                for (int i = 0; i < 4; i++) pend_m[k][i] = dfr_c[k][i] && run && e[i];
                case (st_m[k])
                    2'b00: if (s) st_m[k] = 2'b01;
                    2'b01: begin
                        if (lim_c[k] != 0 && cnt_m[k][0] == 64'(lim_c[k])) st_m[k] = 2'b10;
                        else if (!s) st_m[k] = 2'b00;
                    end
                    default: st_m[k] = st_m[k];
                endcase
            end
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 4; k++) begin
            logic [4:0]  eo;
            logic [63:0] erd;
            for (int j = 0; j < 5; j++) eo[j] = OVF_EN && ovf_m[k][j];
            erd = (rd_sel <= 3'd4) ? shd_m[k][rd_sel] : 64'd0;
            chk($sformatf("u%0d.state", k), 64'(st_w[k]), 64'(st_m[k]));
            chk($sformatf("u%0d.done", k), 64'(done_w[k]), 64'(st_m[k] == 2'b10));
            chk($sformatf("u%0d.ovf", k), 64'(ovf_w[k]), 64'(eo));
            chk($sformatf("u%0d.irq", k), 64'(irq_w[k]), 64'(|eo));
            chk($sformatf("u%0d.rd[%0d]", k, rd_sel), obs_rd(k), erd);
        end
    endtask

    task automatic step(input bit s, input bit c, input bit [3:0] e, input bit sn);
        start = s;
        clr   = c;
        evt   = e;
        snap  = sn;
        @(posedge clk);
        model_step(s, c, e, sn);
        @(negedge clk);
        check_all();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        check_all();
        rst = 1'b1;

        // Limited run with three event pulses on channel 0.
        step(0, 1, 4'h0, 0);
        step(1, 0, 4'h0, 0);
        for (int i = 0; i < 34; i++) begin
            step(1, 0, (i == 2 || i == 5 || i == 9) ? 4'h1 : 4'h0, 0);
            chk("a.done_from_30", 64'(done_w[0]), 64'(i >= 29));
        end
        step(1, 0, 4'h0, 1);
        rd_sel = 3'd0; #1 chk("a.cyc30", obs_rd(0), 64'd30);
        rd_sel = 3'd1; #1 chk("a.evt0_3", obs_rd(0), 64'd3);

        // Deferred event on the final RUN cycle.
        step(0, 1, 4'h0, 0);
        step(1, 0, 4'h0, 0);
        for (int i = 0; i < 29; i++) step(1, 0, 4'h0, 0);
        step(1, 0, 4'h1, 0);
        chk("b.state_done", 64'(st_w[1]), 64'd2);
        step(1, 0, 4'h0, 1);
        rd_sel = 3'd1; #1 chk("b.defer_pre", obs_rd(1), 64'd0);
        chk("a.last_evt", obs_rd(0), 64'd1);
        step(1, 0, 4'h0, 1);
        chk("b.defer_post", obs_rd(1), 64'd1);

        // 256 events on 8-bit counters: wrap vs saturate.
        step(0, 1, 4'h0, 0);
        step(1, 0, 4'h0, 0);
        for (int i = 0; i < 256; i++) step(1, 0, 4'h1, 0);
        step(1, 0, 4'h0, 1);
        chk("c.wrap", obs_rd(2), 64'd0);
        chk("d.sat", obs_rd(3), 64'd255);
        chk("c.ovf1", 64'(ovf_w[2][1]), 64'(OVF_EN));
        chk("c.irq", 64'(irq_w[2]), 64'(OVF_EN));

        // Pause and resume.
        step(0, 1, 4'h0, 0);
        step(1, 0, 4'h0, 0);
        for (int i = 0; i < 9; i++) step(1, 0, 4'h0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 4'h0, 0);
        chk("c.paused", 64'(st_w[2]), 64'd0);
        rd_sel = 3'd0;
        step(0, 0, 4'h0, 1);
        chk("c.frozen", obs_rd(2), 64'd10);
        step(1, 0, 4'h0, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 4'h0, 0);
        step(1, 0, 4'h0, 1);
        chk("c.resumed", obs_rd(2), 64'd13);

        // Clear and snapshot on the same edge.
        step(0, 1, 4'h0, 0);
        step(1, 0, 4'h0, 0);
        for (int i = 0; i < 17; i++) step(1, 0, 4'h0, 0);
        step(1, 1, 4'h0, 1);
        chk("c.snap_clr", obs_rd(2), 64'd17);
        chk("c.clr_idle", 64'(st_w[2]), 64'd0);
        step(0, 0, 4'h0, 1);
        chk("c.live_zero", obs_rd(2), 64'd0);

        // Asynchronous reset between edges with a deferred event pending.
        step(0, 1, 4'h0, 0);
        step(1, 0, 4'h0, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 4'h1, 1);
        start = 1'b0;
        evt   = 4'h0;
        snap  = 1'b0;
        rd_sel = 3'd1;
        #2 rst = 1'b0;
        model_reset();
        #1 check_all();
        chk("b.rst_rd", obs_rd(1), 64'd0);
        #1 rst = 1'b1;
        step(0, 0, 4'h0, 0);
        step(0, 0, 4'h0, 1);
        step(0, 0, 4'h0, 0);
        chk("b.pend_dropped", obs_rd(1), 64'd0);

        // Random traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            rd_sel = 3'($urandom_range(0, 7));
            step($urandom_range(0, 9) != 0, $urandom_range(0, 39) == 0,
                 4'($urandom), $urandom_range(0, 3) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
